rvfi_reorder: RTL and testbench
===============================

Name: rvfi_reorder

Overview:
- Collects retirements from NRET parallel RVFI channels and emits them as one single-channel stream in strict ascending rvfi_order.
- Out-of-order and multi-issue cores can then be fed to single-channel checkers and trace writers.
- Sits between the core's RVFI port and any consumer that expects one retirement per cycle in program order.
- Channel payloads other than valid/order arrive pre-packed as an opaque PW-bit word.

Parameters:
- NRET, 2, number of input retirement channels (>=1).
- PW, 256, payload width per channel in bits (packed insn/trap/pc/rd/mem fields).
- DEPTH, 8, reorder-buffer slots; power of two, >= NRET.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- rvfi_valid  in  NRET  per-channel retirement valid; channel i is bit i.
- rvfi_order  in  NRET*64  per-channel order; channel i is bits [i*64 +: 64].
- rvfi_payload  in  NRET*PW  per-channel payload; channel i is bits [i*PW +: PW].
- out_valid  out  1  output retirement valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_order  out  64  order of the output retirement.
- out_payload  out  PW  payload of the output retirement.
- out_channel  out  $clog2(NRET) (min 1)  source channel index of the output retirement.
- occupancy  out  $clog2(DEPTH+1)  buffer slots in use; excludes the output register.
- error  out  1  sticky protocol/overflow flag.

Behaviour:
- Reset values: out_valid=0, out_order=0, out_payload=0, out_channel=0, occupancy=0, error=0. Internal state also clears: all slots empty, next_order=0.
- Reset asserted mid-stream drops all buffered and output-stage entries with no partial output.
- Buffer storage: slot index = order[log2(DEPTH)-1:0]. Each slot holds a valid bit, the 64-bit order, the payload and the source channel.
- Capture: each cycle, every channel with rvfi_valid=1 is accepted if all of the following hold:
  - next_order <= order < next_order+DEPTH, evaluated with the pre-edge next_order using 64-bit unsigned arithmetic;
  - the target slot is empty;
  - no lower-index channel targets the same slot this cycle.
- Rejection: a channel failing any capture condition is dropped and error is set on the next edge.
- The input has no backpressure; overflow is an error, not a stall.
- Dequeue: fires when slot[next_order mod DEPTH] is valid, its stored order == next_order, and (out_valid==0 or out_ready==1).
  - On the dequeue edge: the slot is copied into the output register, the slot is cleared, next_order increments by 1, and out_valid=1.
- A slot freed by dequeue is not reusable by a capture on the same edge; the window check uses the pre-edge next_order.
- Output hold: out_valid && !out_ready → out_order, out_payload and out_channel are held stable.
- out_valid && out_ready with no dequeue possible → out_valid=0 next cycle.
- Throughput: one retirement per cycle.
- Latency: rvfi_valid in cycle n → out_valid earliest in cycle n+2.
- occupancy next = occupancy + captures − (dequeue ? 1 : 0). It never exceeds DEPTH.
- error stays set until reset. Operation continues after an error with the offending entries discarded.
- next_order wraps modulo 2^64; the window comparison is modular-safe.

Test Plan:
- NRET=2: ch0 order 0 and ch1 order 1 in cycle 0, out_ready=1 → out_order 0 in cycle 2 (out_channel 0), order 1 in cycle 3 (out_channel 1); error=0.
- Reverse arrival: order 1 on ch0 in cycle 0, order 0 on ch1 in cycle 3 → nothing output before cycle 5; then orders 0 and 1 on consecutive cycles.
- out_ready=0 for 4 cycles while 3 entries are buffered → out_valid stays high with order 0 held, occupancy=2; releasing out_ready drains orders 0, 1, 2 back-to-back.
- Overflow: DEPTH=8, next_order=0, order 8 presented → dropped; error=1 next cycle; occupancy unchanged; subsequent in-window orders still output correctly.
- Duplicate: order 3 on ch0 and ch1 in the same cycle → only ch0's payload is stored; error=1. Also order 0 re-presented after it was output → error=1.
- Reset asserted asynchronously with 5 entries buffered and out_valid=1 → all outputs 0 immediately; order 0 after release outputs normally.

Source files
------------

// File: rtl/rvfi_reorder.sv
// rvfi_reorder
//   Merges NRET parallel RVFI retirement channels into one stream that is
//   strictly ascending in rvfi_order. Entries are parked in a DEPTH-slot
//   buffer indexed by order[log2(DEPTH)-1:0] and released one per cycle
//   into a single output register.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   rvfi_valid/order/   per-channel retirement inputs (channel i at bit i,
//   rvfi_payload        order bits [i*64 +: 64], payload bits [i*PW +: PW])
//   out_valid/ready     output handshake: a transfer happens on a clock edge
//                       where out_valid && out_ready; while out_valid is high
//                       and out_ready is low the output fields are held.
//                       The input side has no backpressure.
//   out_order/payload/  fields of the retirement in the output register
//   out_channel
//   occupancy           buffer slots in use (output register not counted)
//   error               sticky: an input was rejected (out of window,
//                       slot busy, or same-slot collision with a lower channel)
module rvfi_reorder #(
  parameter int NRET  = 2,
  parameter int PW    = 256,
  parameter int DEPTH = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NRET-1:0]                 rvfi_valid,
  input  logic [NRET*64-1:0]              rvfi_order,
  input  logic [NRET*PW-1:0]              rvfi_payload,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [63:0]                     out_order,
  output logic [PW-1:0]                   out_payload,
  output logic [(NRET>1 ? $clog2(NRET) : 1)-1:0] out_channel,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy,
  output logic                            error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  // reorder buffer
  logic          slot_vld_q [DEPTH];
  logic [63:0]   slot_ord_q [DEPTH];
  logic [PW-1:0] slot_pl_q  [DEPTH];
  logic [CW-1:0] slot_ch_q  [DEPTH];

  logic [63:0]   next_order_q;
  logic          out_valid_q;
  logic [63:0]   out_order_q;
  logic [PW-1:0] out_pl_q;
  logic [CW-1:0] out_ch_q;
  logic [OW-1:0] occ_q, occ_d;
  logic          err_q;

  logic [NRET-1:0] cap;
  logic [NRET-1:0] rej;
  logic [AW-1:0]   cap_idx [NRET];
  logic [OW-1:0]   cap_cnt;
  logic [AW-1:0]   head_idx;
  logic            deq;

  assign head_idx = next_order_q[AW-1:0];

  // Capture decision per channel. The window test uses the difference
  // order - next_order so it stays correct across the 2^64 wrap.
  always_comb begin
    cap     = '0;
    rej     = '0;
    cap_cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      logic [63:0] ord_i;
      logic [63:0] diff_i;
      logic        clash_i;
      ord_i      = rvfi_order[i*64 +: 64];
      diff_i     = ord_i - next_order_q;
      cap_idx[i] = ord_i[AW-1:0];
      clash_i    = 1'b0;
      for (int j = 0; j < NRET; j++) begin
        if (j < i && rvfi_valid[j] && rvfi_order[j*64 +: AW] == ord_i[AW-1:0])
          clash_i = 1'b1;
      end
      if (rvfi_valid[i]) begin
        if (diff_i < 64'(DEPTH) && !slot_vld_q[cap_idx[i]] && !clash_i)
          cap[i] = 1'b1;
        else
          rej[i] = 1'b1;
      end
      cap_cnt = cap_cnt + OW'(cap[i]);
    end
  end

  // The head slot is busy pre-edge whenever deq fires, so a capture can
  // never land in the slot being freed on the same edge.
  assign deq   = slot_vld_q[head_idx] && (slot_ord_q[head_idx] == next_order_q) &&
                 (!out_valid_q || out_ready);
  assign occ_d = occ_q + cap_cnt - OW'(deq);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        slot_vld_q[s] <= 1'b0;
        slot_ord_q[s] <= '0;
        slot_pl_q[s]  <= '0;
        slot_ch_q[s]  <= '0;
      end
      next_order_q <= '0;
      out_valid_q  <= 1'b0;
      out_order_q  <= '0;
      out_pl_q     <= '0;
      out_ch_q     <= '0;
      occ_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      if (deq) begin
        slot_vld_q[head_idx] <= 1'b0;
        out_valid_q          <= 1'b1;
        out_order_q          <= slot_ord_q[head_idx];
        out_pl_q             <= slot_pl_q[head_idx];
        out_ch_q             <= slot_ch_q[head_idx];
        next_order_q         <= next_order_q + 64'd1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      for (int i = 0; i < NRET; i++) begin
        if (cap[i]) begin
          slot_vld_q[cap_idx[i]] <= 1'b1;
          slot_ord_q[cap_idx[i]] <= rvfi_order[i*64 +: 64];
          slot_pl_q[cap_idx[i]]  <= rvfi_payload[i*PW +: PW];
          slot_ch_q[cap_idx[i]]  <= CW'(i);
        end
      end
      occ_q <= occ_d;
      if (|rej) err_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_order   = out_order_q;
  assign out_payload = out_pl_q;
  assign out_channel = out_ch_q;
  assign occupancy   = occ_q;
  assign error       = err_q;
endmodule

// File: tb/tb_rvfi_reorder.sv
module tb_rvfi_reorder;
  localparam int NRET  = 2;
  localparam int PW    = 256;
  localparam int DEPTH = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NRET-1:0]   rvfi_valid = '0;
  logic [NRET*64-1:0] rvfi_order = '0;
  logic [NRET*PW-1:0] rvfi_payload = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [63:0]       out_order;
  logic [PW-1:0]     out_payload;
  logic [0:0]        out_channel;
  logic [3:0]        occupancy;
  logic              error;

  int total = 0;
  int bad   = 0;
  logic [71:0] exp_q[$];   // {channel byte, order}

  rvfi_reorder #(.NRET(NRET), .PW(PW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_payload(rvfi_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order),
    .out_payload(out_payload), .out_channel(out_channel),
    .occupancy(occupancy), .error(error)
  );

  // clock/reset
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pl(input logic [63:0] ord, input int ch);
    pl = {184'h0, 8'(ch + 8'hA0), ord};
  endfunction

  // driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at that same point
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input int ch, input logic [63:0] ord);
    rvfi_valid[ch]            = 1'b1;
    rvfi_order[ch*64 +: 64]   = ord;
    rvfi_payload[ch*PW +: PW] = pl(ord, ch);
  endtask

  task automatic clear_in();
    rvfi_valid   = '0;
    rvfi_order   = '0;
    rvfi_payload = '0;
  endtask

  task automatic reset_dut();
    clear_in();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [63:0] ord, input int ch);
    chk({tag, "_valid"}, 256'(out_valid), 256'(1));
    chk({tag, "_order"}, 256'(out_order), 256'(ord));
    chk({tag, "_chan"}, 256'(out_channel), 256'(ch));
    chk({tag, "_pl"}, out_payload, pl(ord, ch));
  endtask

  // scoreboard drain with out_ready=1: each sampled valid output transfers
  // at the next edge, so entries must appear on consecutive samples
  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < budget) begin
      if (out_valid) begin
        logic [71:0] e;
        e = exp_q.pop_front();
        check_out(tag, e[63:0], int'(e[71:64]));
      end
      tick();
      cyc++;
    end
    chk({tag, "_drained"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_order", 256'(out_order), 256'(0));
    chk("rst_pl", out_payload, 256'(0));
    chk("rst_chan", 256'(out_channel), 256'(0));
    chk("rst_occ", 256'(occupancy), 256'(0));
    chk("rst_err", 256'(error), 256'(0));
    tick();
    reset = 1'b0;
    tick();

    // in-order pair: out order 0 in cycle 2, order 1 in cycle 3
    out_ready = 1'b1;
    present(0, 64'd0); present(1, 64'd1);
    tick(); clear_in();
    chk("pair_c1_valid", 256'(out_valid), 256'(0));
    chk("pair_c1_occ", 256'(occupancy), 256'(2));
    tick();
    check_out("pair_c2", 64'd0, 0);
    chk("pair_c2_occ", 256'(occupancy), 256'(1));
    tick();
    check_out("pair_c3", 64'd1, 1);
    tick();
    chk("pair_c4_valid", 256'(out_valid), 256'(0));
    chk("pair_err", 256'(error), 256'(0));

    // reverse arrival
    reset_dut();
    present(0, 64'd1);
    tick(); clear_in();
    chk("rev_c1_valid", 256'(out_valid), 256'(0));
    tick();
    chk("rev_c2_valid", 256'(out_valid), 256'(0));
    tick();
    chk("rev_c3_valid", 256'(out_valid), 256'(0));
    present(1, 64'd0);
    tick(); clear_in();
    chk("rev_c4_valid", 256'(out_valid), 256'(0));
    tick();
    check_out("rev_c5", 64'd0, 1);
    tick();
    check_out("rev_c6", 64'd1, 0);
    tick();
    chk("rev_c7_valid", 256'(out_valid), 256'(0));
    chk("rev_err", 256'(error), 256'(0));

    // backpressure hold, then back-to-back drain
    reset_dut();
    out_ready = 1'b0;
    present(0, 64'd0); present(1, 64'd1);
    tick(); clear_in();
    present(0, 64'd2);
    tick(); clear_in();
    for (int k = 0; k < 4; k++) begin
      check_out("hold", 64'd0, 0);
      chk("hold_occ", 256'(occupancy), 256'(2));
      tick();
    end
    exp_q.push_back({8'd0, 64'd0});
    exp_q.push_back({8'd1, 64'd1});
    exp_q.push_back({8'd0, 64'd2});
    drain("bp", 3);
    chk("bp_empty_valid", 256'(out_valid), 256'(0));
    chk("bp_occ", 256'(occupancy), 256'(0));

    // overflow: order 8 outside window [0,8)
    reset_dut();
    present(0, 64'd8);
    tick(); clear_in();
    chk("ovf_err", 256'(error), 256'(1));
    chk("ovf_occ", 256'(occupancy), 256'(0));
    chk("ovf_valid", 256'(out_valid), 256'(0));
    present(0, 64'd0); present(1, 64'd1);
    tick(); clear_in();
    tick();
    check_out("ovf_after0", 64'd0, 0);
    tick();
    check_out("ovf_after1", 64'd1, 1);
    chk("ovf_err_sticky", 256'(error), 256'(1));

    // stale order: 0 re-presented after it was output
    reset_dut();
    present(0, 64'd0);
    tick(); clear_in();
    tick();
    check_out("stale_first", 64'd0, 0);
    chk("stale_err_before", 256'(error), 256'(0));
    present(0, 64'd0);
    tick(); clear_in();
    chk("stale_err", 256'(error), 256'(1));
    chk("stale_occ", 256'(occupancy), 256'(0));

    // duplicate order 3 on both channels: ch0 wins
    reset_dut();
    present(0, 64'd3); present(1, 64'd3);
    tick(); clear_in();
    chk("dup_err", 256'(error), 256'(1));
    chk("dup_occ", 256'(occupancy), 256'(1));
    present(0, 64'd0); present(1, 64'd1);
    tick(); clear_in();
    present(1, 64'd2);
    tick(); clear_in();
    exp_q.push_back({8'd0, 64'd0});
    exp_q.push_back({8'd1, 64'd1});
    exp_q.push_back({8'd1, 64'd2});
    exp_q.push_back({8'd0, 64'd3});
    drain("dup", 6);

    // asynchronous reset with 5 entries held
    reset_dut();
    out_ready = 1'b0;
    present(0, 64'd0); present(1, 64'd1);
    tick(); clear_in();
    present(0, 64'd2); present(1, 64'd3);
    tick(); clear_in();
    present(0, 64'd4);
    tick(); clear_in();
    chk("ar_pre_occ", 256'(occupancy), 256'(4));
    chk("ar_pre_valid", 256'(out_valid), 256'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 256'(out_valid), 256'(0));
    chk("ar_order", 256'(out_order), 256'(0));
    chk("ar_pl", out_payload, 256'(0));
    chk("ar_chan", 256'(out_channel), 256'(0));
    chk("ar_occ", 256'(occupancy), 256'(0));
    chk("ar_err", 256'(error), 256'(0));
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    present(1, 64'd0);
    tick(); clear_in();
    chk("ar_post_c1_valid", 256'(out_valid), 256'(0));
    tick();
    check_out("ar_post", 64'd0, 1);
    chk("ar_post_err", 256'(error), 256'(0));
    tick();
    chk("ar_post_idle", 256'(out_valid), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // time limit
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
